// File: rtl/codec_model_pkg.sv
// Shared constants and parameter-derivation helpers for the audio codec model.
// Pure compile-time content; no logic, no latency, no flow control.
package codec_model_pkg;

  localparam int MODE_LJ  = 0;
  localparam int MODE_I2S = 1;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // XCK cycles in one full stereo frame.
  function automatic int frame_len(input int bclk_div, input int bits_per_ch);
    return 2 * bclk_div * bits_per_ch;
  endfunction

endpackage

// File: rtl/codec_clkgen.sv
// Frame timing: div/slot/half counters, registered BCLK, LRCK and frame strobes.
// Strobes are decodes of the current counter state (0-cycle); BCLK is 1 cycle registered.
// No backpressure: free-running from reset release.
module codec_clkgen
  import codec_model_pkg::*;
#(
  parameter int  BCLK_DIV    = 8,
  parameter int  BITS_PER_CH = 32,
  parameter int  MODE        = MODE_LJ,
  localparam int SW          = cnt_w(BITS_PER_CH)
) (
  input  logic          aud_xck,
  input  logic          reset_n,
  output logic [SW-1:0] slot,
  output logic          half,
  output logic          bclk,
  output logic          lrck,
  output logic          rise_stb,
  output logic          fall_stb,
  output logic          pre_end,
  output logic          frame_end
);

  localparam int DW = cnt_w(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE   = DW'(BCLK_DIV - 2);
  localparam logic [DW-1:0] DIV_MID   = DW'(BCLK_DIV / 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(BITS_PER_CH - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic          div_wrap;
  logic          slot_last;

  assign div_wrap  = (div == DIV_LAST);
  assign slot_last = (slot == SLOT_LAST);
  assign div_nxt   = div_wrap ? '0 : div + 1'b1;

  always_ff @(posedge aud_xck or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      slot <= '0;
      half <= 1'b0;
      bclk <= 1'b0;
    end else begin
      div <= div_nxt;
      // BCLK is registered from the next divider value so it never glitches.
      bclk <= (div_nxt >= DIV_MID);
      if (div_wrap) begin
        slot <= slot_last ? '0 : slot + 1'b1;
        if (slot_last) begin
          half <= ~half;
        end
      end
    end
  end

  // Left channel is LRCK high in left-justified mode and LRCK low in I2S.
  assign lrck      = (MODE == MODE_I2S) ? half : ~half;
  assign rise_stb  = (div == DIV_MID);
  assign fall_stb  = (div == '0);
  assign pre_end   = half && slot_last && (div == DIV_PRE);
  assign frame_end = half && slot_last && div_wrap;

endmodule

// File: rtl/codec_model.sv
// Audio codec model: serialises an ADC test source and captures the FPGA's DAC stream.
// DAC words appear with dac_valid on the last XCK cycle of each frame; ADC words latch per frame.
// No backpressure. Build option CODEC_MODEL_LOOPBACK_EN echoes the previous DAC frame on ADC.
module codec_model
  import codec_model_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BCLK_DIV    = 8,
  parameter int BITS_PER_CH = 32,
  parameter int MODE        = MODE_LJ
) (
  input  logic              AUD_XCK,
  input  logic              reset_n,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_ADCLRCK,
  output logic              AUD_ADCDAT,
  input  logic              AUD_DACDAT,
  input  logic [DATA_W-1:0] ramp_step,
  output logic [DATA_W-1:0] dac_left,
  output logic [DATA_W-1:0] dac_right,
  output logic              dac_valid,
  output logic [15:0]       frame_count
);

  localparam int SW         = cnt_w(BITS_PER_CH);
  localparam int FIRST_SLOT = (MODE == MODE_I2S) ? 1 : 0;
  localparam int LAST_SLOT  = FIRST_SLOT + DATA_W - 1;

  logic [SW-1:0] slot;
  logic          half;
  logic          lrck;
  logic          rise_stb;
  logic          fall_stb;
  logic          pre_end;
  logic          frame_end;
  logic          in_win;
  logic          at_first;

  codec_clkgen #(
    .BCLK_DIV    (BCLK_DIV),
    .BITS_PER_CH (BITS_PER_CH),
    .MODE        (MODE)
  ) u_clkgen (
    .aud_xck   (AUD_XCK),
    .reset_n   (reset_n),
    .slot      (slot),
    .half      (half),
    .bclk      (AUD_BCLK),
    .lrck      (lrck),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .pre_end   (pre_end),
    .frame_end (frame_end)
  );

  assign AUD_DACLRCK = lrck;
  assign AUD_ADCLRCK = lrck;

  assign in_win   = (int'(slot) >= FIRST_SLOT) && (int'(slot) <= LAST_SLOT);
  assign at_first = (int'(slot) == FIRST_SLOT);

  // ADC sample source: both variants present new words from the first cycle of a frame.
  logic [DATA_W-1:0] adc_l;
  logic [DATA_W-1:0] adc_r;

`ifdef CODEC_MODEL_LOOPBACK_EN
  logic [DATA_W-1:0] lb_l;
  logic [DATA_W-1:0] lb_r;
  logic              unused_ramp;

  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      lb_l <= '0;
      lb_r <= '0;
    end else if (frame_end) begin
      lb_l <= dac_left;
      lb_r <= dac_right;
    end
  end

  assign adc_l       = lb_l;
  assign adc_r       = lb_r;
  assign unused_ramp = ^ramp_step;
`else
  logic [DATA_W-1:0] acc;

  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (frame_end) begin
      acc <= acc + ramp_step;
    end
  end

  assign adc_l = acc;
  assign adc_r = ~acc;
`endif

  // ADC serialiser: MSB loaded on the first data slot, then shifted out each BCLK fall.
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] tx_sh;

  assign tx_word = half ? adc_r : adc_l;

  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      AUD_ADCDAT <= 1'b0;
      tx_sh      <= '0;
    end else if (fall_stb) begin
      if (at_first) begin
        AUD_ADCDAT <= tx_word[DATA_W-1];
        tx_sh      <= tx_word << 1;
      end else if (in_win) begin
        AUD_ADCDAT <= tx_sh[DATA_W-1];
        tx_sh      <= tx_sh << 1;
      end else begin
        AUD_ADCDAT <= 1'b0;
      end
    end
  end

  // DAC deserialiser, one shifter per channel.
  logic [DATA_W-1:0] rx_l;
  logic [DATA_W-1:0] rx_r;
  logic [DATA_W-1:0] rx_l_nxt;
  logic [DATA_W-1:0] rx_r_nxt;

  always_comb begin
    rx_l_nxt = rx_l;
    rx_r_nxt = rx_r;
    if (rise_stb && in_win) begin
      if (half) begin
        rx_r_nxt = {rx_r[DATA_W-2:0], AUD_DACDAT};
      end else begin
        rx_l_nxt = {rx_l[DATA_W-2:0], AUD_DACDAT};
      end
    end
  end

  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      rx_l <= '0;
      rx_r <= '0;
    end else begin
      rx_l <= rx_l_nxt;
      rx_r <= rx_r_nxt;
    end
  end

  // Loading one cycle early makes the new words and dac_valid coincide with the last frame cycle;
  // the *_nxt taps catch a final data bit sampled on that same edge.
  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      dac_left    <= '0;
      dac_right   <= '0;
      dac_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      dac_valid <= pre_end;
      if (pre_end) begin
        dac_left    <= rx_l_nxt;
        dac_right   <= rx_r_nxt;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_codec_model.sv
// Directed bench: LJ and I2S instances share one clock/reset; the bench plays the FPGA side.
// Build with CODEC_MODEL_LOOPBACK_EN to exercise the loopback source at DATA_W=24.
`timescale 1ns/1ps
module tb_codec_model;
  import codec_model_pkg::*;

`ifdef CODEC_MODEL_LOOPBACK_EN
  localparam int DW = 24;
`else
  localparam int DW = 16;
`endif
  localparam int FRAME = frame_len(8, 32);

  logic          AUD_XCK = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] ramp_step;

  logic          bclk_lj, dlr_lj, alr_lj, adc_lj, dacdat_lj, vld_lj;
  logic [DW-1:0] dl_lj, dr_lj;
  logic [15:0]   fc_lj;
  logic          bclk_i2s, dlr_i2s, alr_i2s, adc_i2s, dacdat_i2s, vld_i2s;
  logic [DW-1:0] dl_i2s, dr_i2s;
  logic [15:0]   fc_i2s;

  always #5 AUD_XCK = ~AUD_XCK;

  codec_model #(.DATA_W(DW), .BCLK_DIV(8), .BITS_PER_CH(32), .MODE(MODE_LJ)) u_lj (
    .AUD_XCK(AUD_XCK), .reset_n(reset_n), .AUD_BCLK(bclk_lj), .AUD_DACLRCK(dlr_lj),
    .AUD_ADCLRCK(alr_lj), .AUD_ADCDAT(adc_lj), .AUD_DACDAT(dacdat_lj), .ramp_step(ramp_step),
    .dac_left(dl_lj), .dac_right(dr_lj), .dac_valid(vld_lj), .frame_count(fc_lj)
  );

  codec_model #(.DATA_W(DW), .BCLK_DIV(8), .BITS_PER_CH(32), .MODE(MODE_I2S)) u_i2s (
    .AUD_XCK(AUD_XCK), .reset_n(reset_n), .AUD_BCLK(bclk_i2s), .AUD_DACLRCK(dlr_i2s),
    .AUD_ADCLRCK(alr_i2s), .AUD_ADCDAT(adc_i2s), .AUD_DACDAT(dacdat_i2s), .ramp_step(ramp_step),
    .dac_left(dl_i2s), .dac_right(dr_i2s), .dac_valid(vld_i2s), .frame_count(fc_i2s)
  );

  logic [31:0]   tbl_l [4];
  logic [31:0]   tbl_r [4];
  logic [DW-1:0] cap_lj [2];
  logic [DW-1:0] cap_i2s [2];
  logic [DW-1:0] acc_m, prev_l, prev_r;
  int            n_chk, n_fail;
  int            c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (state %0d)", tag, got, exp, c);
    end
  endtask

  // Word the FPGA sends for frame f, channel h.
  function automatic logic [DW-1:0] word(input int f, input int h);
    logic [31:0] t;
    t = (h != 0) ? tbl_r[f % 4] : tbl_l[f % 4];
    return t[DW-1:0];
  endfunction

  function automatic logic dac_bit(input logic [DW-1:0] w, input int s, input int off);
    logic [DW-1:0] t;
    int rel;
    rel = s - off;
    if (rel < 0 || rel >= DW) return 1'b0;
    t = w >> (DW - 1 - rel);
    return t[0];
  endfunction

  function automatic logic [DW-1:0] exp_adc(input int h);
`ifdef CODEC_MODEL_LOOPBACK_EN
    return (h != 0) ? prev_r : prev_l;
`else
    return (h != 0) ? ~acc_m : acc_m;
`endif
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_bclk"},  bclk_lj, 0);
    check({tag, "_adc_lj"},  adc_lj, 0);
    check({tag, "_adc_i2s"}, adc_i2s, 0);
    check({tag, "_lrck_lj"}, dlr_lj, 1);
    check({tag, "_adclrck_lj"}, alr_lj, 1);
    check({tag, "_lrck_i2s"}, dlr_i2s, 0);
    check({tag, "_dacl"}, dl_lj, 0);
    check({tag, "_dacr"}, dr_i2s, 0);
    check({tag, "_vld_lj"},  vld_lj, 0);
    check({tag, "_vld_i2s"}, vld_i2s, 0);
    check({tag, "_fc_lj"},  fc_lj, 0);
    check({tag, "_fc_i2s"}, fc_i2s, 0);
  endtask

  // One XCK state: drive the FPGA DAC bit, sample/score the DUT outputs.
  task automatic do_state();
    int p, f, d, s, h;
    logic [DW-1:0] w;
    p = c % FRAME;
    f = c / FRAME;
    d = p % 8;
    s = (p / 8) % 32;
    h = p / (FRAME / 2);
    w = word(f, h);
    dacdat_lj  = dac_bit(w, s, 0);
    dacdat_i2s = dac_bit(w, s, 1);

    if (c < 16) check("bclk_lj", bclk_lj, d >= 4);
    if (c < 2 * FRAME && (p == 0 || p == 255 || p == 256 || p == 511)) begin
      check("lrck_lj", dlr_lj, h == 0);
      check("adclrck_lj", alr_lj, h == 0);
      check("lrck_i2s", dlr_i2s, h == 1);
    end

    if (d == 4) begin
      if (s < DW) cap_lj[h] = {cap_lj[h][DW-2:0], adc_lj};
      else if (s == DW + 2 && c < FRAME) check("adc_idle_lj", adc_lj, 0);
      if (s >= 1 && s <= DW) cap_i2s[h] = {cap_i2s[h][DW-2:0], adc_i2s};
      else if (s == 0 && c < 2 * FRAME) check("adc_slot0_i2s", adc_i2s, 0);
    end

    if (p == FRAME - 2) check("vld_before_end", vld_lj, 0);
    if (p == 0 && c > 0) check("vld_after_end", vld_i2s, 0);
    if (p == FRAME - 1) begin
      check("vld_lj", vld_lj, 1);
      check("vld_i2s", vld_i2s, 1);
      check("dacl_lj", dl_lj, word(f, 0));
      check("dacr_lj", dr_lj, word(f, 1));
      check("dacl_i2s", dl_i2s, word(f, 0));
      check("dacr_i2s", dr_i2s, word(f, 1));
      check("fcount_lj", fc_lj, (f + 1) & 16'hFFFF);
      check("adcl_lj", cap_lj[0], exp_adc(0));
      check("adcr_lj", cap_lj[1], exp_adc(1));
      check("adcl_i2s", cap_i2s[0], exp_adc(0));
      check("adcr_i2s", cap_i2s[1], exp_adc(1));
      acc_m  = acc_m + ramp_step;
      prev_l = word(f, 0);
      prev_r = word(f, 1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    c = 0;
    acc_m = '0;
    prev_l = '0;
    prev_r = '0;
    ramp_step = DW'(16'h0100);
    dacdat_lj = 1'b0;
    dacdat_i2s = 1'b0;
    tbl_l[0] = 32'h00A5A5C3; tbl_r[0] = 32'h00341234;
    tbl_l[1] = 32'h00800001; tbl_r[1] = 32'h007FFFFE;
    tbl_l[2] = 32'h00FFFFFF; tbl_r[2] = 32'h00000000;
    tbl_l[3] = 32'h00135555; tbl_r[3] = 32'h00AAAA00;
    cap_lj[0] = '0; cap_lj[1] = '0; cap_i2s[0] = '0; cap_i2s[1] = '0;

    repeat (3) @(negedge AUD_XCK);
    check_reset("rst0");
    reset_n = 1'b1;

    // Seven frames free-running, then reset in the middle of the eighth.
    while (c != 7 * FRAME + 300) begin
      do_state();
      if (c == 4 * FRAME + 100) ramp_step = '1;
      @(negedge AUD_XCK);
      c++;
    end

    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge AUD_XCK);
      check("vld_in_rst", vld_lj, 0);
    end

    c = 0;
    acc_m = '0;
    prev_l = '0;
    prev_r = '0;
    reset_n = 1'b1;
    while (c < 2 * FRAME) begin
      do_state();
      @(negedge AUD_XCK);
      c++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
